// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte-lane stores, right-aligned one-cycle loads
// and a power-on clear sequence that walks every word before accepting traffic.
module data_mem_responder #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        read,
  input  logic [31:0] read_address,
  input  logic        write,
  input  logic [31:0] write_address,
  input  logic [31:0] DATA_wb,
  input  logic [1:0]  size,
  output logic [31:0] DATA_in,
  output logic        rvalid,
  output logic        busy,
  output logic        misalign_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic {INIT, READY} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   clr_cnt_q;
  logic [31:0]            mem [DEPTH];

  logic [31:0]            data_p1;
  logic                   vld_p1;
  logic                   err_p1;

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] lane);
    return word >> {lane, 3'b000};
  endfunction

  function automatic logic store_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    return (sz == 2'b10 && lane[0]) || (sz == 2'b11 && lane != 2'b00);
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b01:   return 4'b0001 << lane;
      2'b10:   return lane[1] ? 4'b1100 : 4'b0011;
      2'b11:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the right-aligned store data so each enabled lane sees its byte.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b01:   return {4{d[7:0]}};
      2'b10:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  logic                 rd_req, wr_req;
  logic [ADDR_BITS-1:0] rd_idx, wr_idx;
  logic [1:0]           rd_lane, wr_lane;
  logic                 ld_fire, st_commit, st_reject;
  logic [3:0]           st_be;
  logic [31:0]          st_data;
  logic                 addr_unused;

  // Only a clean 1 counts as a request; X/Z on the strobes is treated as idle.
  assign rd_req  = (read === 1'b1);
  assign wr_req  = (write === 1'b1);
  assign rd_idx  = read_address[ADDR_BITS+1:2];
  assign wr_idx  = write_address[ADDR_BITS+1:2];
  assign rd_lane = read_address[1:0];
  assign wr_lane = write_address[1:0];
  assign addr_unused = ^{read_address[31:ADDR_BITS+2], write_address[31:ADDR_BITS+2]};

  assign ld_fire   = rd_req && (state_q == READY);
  assign st_reject = wr_req && (size != 2'b00)
                     && ((state_q == INIT) || store_misaligned(size, wr_lane));
  assign st_commit = wr_req && (size != 2'b00) && (state_q == READY)
                     && !store_misaligned(size, wr_lane);
  assign st_be     = store_be(size, wr_lane);
  assign st_data   = store_lanes(size, DATA_wb);

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && (&clr_cnt_q))
      state_d = READY;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      data_p1   <= '0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT)
        clr_cnt_q <= clr_cnt_q + 1'b1;
      // ---- stage p1: registered load response and store-reject pulse ----
      vld_p1 <= ld_fire;
      err_p1 <= st_reject;
      if (ld_fire)
        data_p1 <= load_align(mem[rd_idx], rd_lane);
    end
  end

  // Array itself is not reset; the INIT walk zeroes it after every reset release.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[clr_cnt_q] <= '0;
    end else if (st_commit) begin
      for (int b = 0; b < 4; b++)
        if (st_be[b])
          mem[wr_idx][8*b +: 8] <= st_data[8*b +: 8];
    end
  end

  assign DATA_in      = data_p1;
  assign rvalid       = vld_p1;
  assign misalign_err = err_p1;
  assign busy         = (state_q == INIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: byte-addressed reference memory,
// expected loads/rejects queued at issue and popped by an independent monitor.
module tb_data_mem_responder;

  localparam int AB     = 4;
  localparam int NWORDS = 2 ** AB;
  localparam int NBYTES = 4 * NWORDS;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read;
  logic [31:0] read_address;
  logic        write;
  logic [31:0] write_address;
  logic [31:0] DATA_wb;
  logic [1:0]  size;
  logic [31:0] DATA_in;
  logic        rvalid;
  logic        busy;
  logic        misalign_err;

  data_mem_responder #(.ADDR_BITS(AB)) dut (
    .clk(clk), .reset_n(reset_n),
    .read(read), .read_address(read_address),
    .write(write), .write_address(write_address),
    .DATA_wb(DATA_wb), .size(size),
    .DATA_in(DATA_in), .rvalid(rvalid), .busy(busy), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit ready_m = 0;

  logic [7:0]  mb [NBYTES];
  logic [31:0] rd_q[$];
  int          rd_due_q[$];
  int          err_due_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] addr);
    int a    = int'(addr) & (NBYTES - 1);
    int lane = a % 4;
    int base = a - lane;
    logic [31:0] r = '0;
    for (int k = lane; k < 4; k++)
      r |= 32'(mb[base + k]) << (8 * (k - lane));
    return r;
  endfunction

  // Returns 1 when the store must be rejected.
  function automatic bit m_store(input logic [31:0] addr, input logic [31:0] d, input logic [1:0] sz);
    int a = int'(addr) & (NBYTES - 1);
    case (sz)
      2'b01: mb[a] = d[7:0];
      2'b10: begin
        if (a % 2 != 0) return 1;
        mb[a] = d[7:0]; mb[a + 1] = d[15:8];
      end
      2'b11: begin
        if (a % 4 != 0) return 1;
        for (int k = 0; k < 4; k++) mb[a + k] = d[8*k +: 8];
      end
      default: ;
    endcase
    return 0;
  endfunction

  // Monitor: every output event must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rvalid) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rvalid_unexpected actual=1 required=0 (t=%0t)", $time);
      end else begin
        chk("load_data", DATA_in, rd_q.pop_front());
        chk("load_latency", 32'(cyc), 32'(rd_due_q.pop_front()));
      end
    end
    if (reset_n === 1'b1 && misalign_err) begin
      if (err_due_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL misalign_unexpected actual=1 required=0 (t=%0t)", $time);
      end else begin
        chk("misalign_latency", 32'(cyc), 32'(err_due_q.pop_front()));
      end
    end
  end

  task automatic op(input logic rd, input logic [31:0] ra, input logic wr,
                    input logic [31:0] wa, input logic [31:0] wd, input logic [1:0] sz);
    if (ready_m && rd === 1'b1) begin
      rd_q.push_back(m_load(ra));
      rd_due_q.push_back(cyc + 1);
    end
    if (wr === 1'b1 && sz != 2'b00) begin
      if (!ready_m || m_store(wa, wd, sz))
        err_due_q.push_back(cyc + 1);
    end
    read = rd; read_address = ra; write = wr; write_address = wa; DATA_wb = wd; size = sz;
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0; size = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, '0, 1'b0, '0, '0, 2'b00);
  endtask

  task automatic check_in_reset();
    chk("rst_data_in", DATA_in, 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h1);
    chk("rst_misalign", 32'(misalign_err), 32'h0);
  endtask

  // Reset, optionally abort the clear after abort_at cycles, then time the clear.
  task automatic do_reset(input int abort_at, input bit init_poke);
    int n;
    #3;
    reset_n = 1'b0;
    ready_m = 0;
    #1;
    check_in_reset();
    rd_q.delete(); rd_due_q.delete(); err_due_q.delete();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    if (abort_at >= 0) begin
      repeat (abort_at) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_in_reset();
      @(negedge clk);
      reset_n = 1'b1;
    end
    chk("busy_after_release", 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      if (init_poke && n == 1)
        op(1'b1, 32'h10, 1'b1, 32'h10, 32'h12345678, 2'b11);
      else
        idle(1);
      n++;
    end
    chk("busy_cycles", 32'(n), 32'(NWORDS));
    ready_m = 1;
  endtask

  task automatic load_all();
    for (int i = 0; i < NWORDS; i++) op(1'b1, 32'(4 * i), 1'b0, '0, '0, 2'b00);
    idle(2);
  endtask

  initial begin
    reset_n = 1'b0; read = 1'b0; write = 1'b0; size = 2'b00;
    read_address = '0; write_address = '0; DATA_wb = '0;
    #12;
    check_in_reset();
    do_reset(-1, 1'b0);
    load_all();

    // Word store, then byte loads at each lane
    op(1'b0, '0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b11);
    for (int i = 0; i < 4; i++) op(1'b1, 32'h10 + 32'(i), 1'b0, '0, '0, 2'b00);
    idle(2);
    chk("data_hold", DATA_in, 32'h000000DE);

    // Byte and half merges into an existing word
    op(1'b0, '0, 1'b1, 32'h20, 32'h11223344, 2'b11);
    op(1'b0, '0, 1'b1, 32'h22, 32'hFFFFFF55, 2'b01);
    op(1'b1, 32'h20, 1'b0, '0, '0, 2'b00);
    op(1'b0, '0, 1'b1, 32'h22, 32'hFFFFA5A5, 2'b10);
    op(1'b1, 32'h20, 1'b0, '0, '0, 2'b00);
    idle(2);
    chk("half_merge_direct", DATA_in, 32'hA5A53344);

    // Misaligned stores rejected, contents unchanged
    op(1'b0, '0, 1'b1, 32'h30, 32'h01020304, 2'b11);
    op(1'b0, '0, 1'b1, 32'h31, 32'h0000BBBB, 2'b10);
    op(1'b0, '0, 1'b1, 32'h42, 32'hCCCCCCCC, 2'b11);
    op(1'b0, '0, 1'b1, 32'h44, 32'h77777777, 2'b00);
    op(1'b1, 32'h30, 1'b0, '0, '0, 2'b00);
    op(1'b1, 32'h40, 1'b0, '0, '0, 2'b00);
    op(1'b1, 32'h44, 1'b0, '0, '0, 2'b00);

    // Same-cycle load and store: load sees pre-write contents
    op(1'b0, '0, 1'b1, 32'h50, 32'h0, 2'b11);
    op(1'b1, 32'h50, 1'b1, 32'h50, 32'hCAFEF00D, 2'b11);
    op(1'b1, 32'h50, 1'b0, '0, '0, 2'b00);
    idle(2);
    chk("rbw_followup", DATA_in, 32'hCAFEF00D);

    // X on read strobe must not start a load
    op(1'bx, 32'h50, 1'b0, '0, '0, 2'b00);
    idle(2);

    // Randomised traffic with aliased upper address bits
    for (int i = 0; i < 400; i++)
      op(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
         2'($urandom_range(0, 3)));
    idle(3);

    // Reset aborted mid-clear, with a store/load poked during INIT
    do_reset(7, 1'b1);
    load_all();
    for (int i = 0; i < 40; i++)
      op(1'($urandom_range(0, 1)), $urandom, 1'b1, $urandom, $urandom, 2'($urandom_range(1, 3)));
    op(1'b1, 32'h0, 1'b1, 32'h0, 32'h89ABCDEF, 2'b11);
    op(1'b1, 32'h0, 1'b0, '0, '0, 2'b00);
    idle(3);

    // Reset after stores: everything reads zero again
    do_reset(-1, 1'b0);
    load_all();

    chk("rd_queue_drained", 32'(rd_q.size()), 32'h0);
    chk("err_queue_drained", 32'(err_due_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
